// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, the legal parameter ranges and the control bundle.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LU_STALL,
        MC_BUSY
    } hz_state_t;

    localparam int unsigned LU_STALL_MIN = 1;
    localparam int unsigned LU_STALL_MAX = 3;
    localparam int unsigned MC_LAT_MIN   = 2;
    localparam int unsigned MC_LAT_MAX   = 32;

    // Wide enough for the largest reload value, MC_LAT_MAX-2.
    localparam int unsigned REM_W = $clog2(MC_LAT_MAX);

    typedef struct packed {
        logic stall_if;
        logic stall_ex;
        logic stall_mem;
        logic flush_ifid;
        logic flush_idex;
        logic bubble_exmem;
    } hz_ctrl_t;

    function automatic logic src_hit(
        input logic       used,
        input logic [7:0] src,
        input logic [7:0] dst
    );
        return used && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_stall_timer.sv
// Remaining-cycle counter shared by the load-use and multi-cycle stall sequences.
// Load has priority over decrement; the counter never decrements below zero.
module hazard_stall_timer
    import hazard_pkg::*;
#(
    parameter int unsigned W = REM_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic [W-1:0] rem,
    output logic         last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= '0;
        end else if (load) begin
            rem <= value;
        end else if (dec && (rem != '0)) begin
            rem <= rem - 1'b1;
        end
    end

    assign last = (rem == W'(1));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, multi-cycle EX stalls, taken-branch
// flushes and memory freeze, plus a saturating stall-cycle counter.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned LU_STALL_CYC = 1,
    parameter int unsigned MC_LAT       = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic              rs1_used_id,
    input  logic              rs2_used_id,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              regwrite_ex,
    input  logic              memread_ex,
    input  logic              mc_start_ex,
    input  logic              branch_taken_ex,
    input  logic              dmem_ready,
    output logic              stall_if,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              bubble_exmem,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    generate
        if (LU_STALL_CYC < LU_STALL_MIN || LU_STALL_CYC > LU_STALL_MAX) begin : g_bad_lu
            $error("hazard_ctrl_unit: LU_STALL_CYC out of range");
        end
        if (MC_LAT < MC_LAT_MIN || MC_LAT > MC_LAT_MAX) begin : g_bad_mc
            $error("hazard_ctrl_unit: MC_LAT out of range");
        end
        if (REG_AW < 1 || REG_AW > 8) begin : g_bad_aw
            $error("hazard_ctrl_unit: REG_AW out of range");
        end
        if (CNT_W < 1) begin : g_bad_cnt
            $error("hazard_ctrl_unit: CNT_W must be positive");
        end
    endgenerate

    localparam logic [REM_W-1:0] LU_RELOAD = REM_W'(LU_STALL_CYC - 1);
    localparam logic [REM_W-1:0] MC_RELOAD = REM_W'(MC_LAT - 2);
    localparam bit               LU_MULTI  = (LU_STALL_CYC >= 2);
    localparam bit               MC_MULTI  = (MC_LAT >= 3);

    hz_state_t        state;
    hz_state_t        state_next;
    logic             freeze;
    logic             lu_hazard;
    logic             tmr_load;
    logic [REM_W-1:0] tmr_value;
    logic             tmr_dec;
    logic [REM_W-1:0] rem;
    logic             rem_last;
    hz_ctrl_t         ctrl;

    assign freeze = !dmem_ready;

    assign lu_hazard = memread_ex && regwrite_ex && (rd_ex != '0) &&
                       (src_hit(rs1_used_id, 8'(rs1_id), 8'(rd_ex)) ||
                        src_hit(rs2_used_id, 8'(rs2_id), 8'(rd_ex)));

    hazard_stall_timer #(
        .W (REM_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .value (tmr_value),
        .dec   (tmr_dec),
        .rem   (rem),
        .last  (rem_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A freeze leaves state and timer untouched; every other input is ignored then.
    always_comb begin
        state_next = state;
        tmr_load   = 1'b0;
        tmr_value  = '0;
        tmr_dec    = 1'b0;
        if (!freeze) begin
            unique case (state)
                IDLE: begin
                    if (branch_taken_ex) begin
                        state_next = IDLE;
                    end else if (mc_start_ex) begin
                        if (MC_MULTI) begin
                            state_next = MC_BUSY;
                            tmr_load   = 1'b1;
                            tmr_value  = MC_RELOAD;
                        end
                    end else if (lu_hazard) begin
                        if (LU_MULTI) begin
                            state_next = LU_STALL;
                            tmr_load   = 1'b1;
                            tmr_value  = LU_RELOAD;
                        end
                    end
                end
                LU_STALL, MC_BUSY: begin
                    if (rem_last) begin
                        state_next = IDLE;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        ctrl = '0;
        if (freeze) begin
            ctrl.stall_if  = 1'b1;
            ctrl.stall_ex  = 1'b1;
            ctrl.stall_mem = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (branch_taken_ex) begin
                        ctrl.flush_ifid = 1'b1;
                        ctrl.flush_idex = 1'b1;
                    end else if (mc_start_ex) begin
                        ctrl.stall_if     = 1'b1;
                        ctrl.stall_ex     = 1'b1;
                        ctrl.bubble_exmem = 1'b1;
                    end else if (lu_hazard) begin
                        ctrl.stall_if   = 1'b1;
                        ctrl.flush_idex = 1'b1;
                    end
                end
                LU_STALL: begin
                    ctrl.stall_if   = 1'b1;
                    ctrl.flush_idex = 1'b1;
                end
                MC_BUSY: begin
                    ctrl.stall_if     = 1'b1;
                    ctrl.stall_ex     = 1'b1;
                    ctrl.bubble_exmem = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

    // Outputs are gated by rst_n so they drop at once, not at the next edge.
    assign stall_if     = rst_n && ctrl.stall_if;
    assign stall_ex     = rst_n && ctrl.stall_ex;
    assign stall_mem    = rst_n && ctrl.stall_mem;
    assign flush_ifid   = rst_n && ctrl.flush_ifid;
    assign flush_idex   = rst_n && ctrl.flush_idex;
    assign bubble_exmem = rst_n && ctrl.bubble_exmem;
    assign busy         = rst_n && (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_if && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed cycles push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       rs1_used_id, rs2_used_id, regwrite_ex, memread_ex;
    logic       mc_start_ex, branch_taken_ex, dmem_ready;
    logic       stall_if, stall_ex, stall_mem, flush_ifid, flush_idex, bubble_exmem, busy;
    logic [3:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [6:0] outs;
        logic [3:0] cnt;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] exp_cnt;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(
        .REG_AW       (5),
        .LU_STALL_CYC (2),
        .MC_LAT       (4),
        .CNT_W        (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rs1_id          (rs1_id),
        .rs2_id          (rs2_id),
        .rs1_used_id     (rs1_used_id),
        .rs2_used_id     (rs2_used_id),
        .rd_ex           (rd_ex),
        .regwrite_ex     (regwrite_ex),
        .memread_ex      (memread_ex),
        .mc_start_ex     (mc_start_ex),
        .branch_taken_ex (branch_taken_ex),
        .dmem_ready      (dmem_ready),
        .stall_if        (stall_if),
        .stall_ex        (stall_ex),
        .stall_mem       (stall_mem),
        .flush_ifid      (flush_ifid),
        .flush_idex      (flush_idex),
        .bubble_exmem    (bubble_exmem),
        .busy            (busy),
        .stall_cnt       (stall_cnt)
    );

    // Output order: stall_if stall_ex stall_mem flush_ifid flush_idex bubble_exmem busy
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [6:0] act;
            e   = sb.pop_front();
            act = {stall_if, stall_ex, stall_mem, flush_ifid, flush_idex, bubble_exmem, busy};
            checks++;
            if ({act, stall_cnt} !== {e.outs, e.cnt}) begin
                failures++;
                $display("FAIL %s: outs=%b cnt=%0d, expected outs=%b cnt=%0d",
                         e.name, act, stall_cnt, e.outs, e.cnt);
            end
        end
    end

    task automatic step(input string nm, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mc, input logic br,
                        input logic rdy, input logic [6:0] eo);
        exp_t e;
        rs1_id = r1; rs2_id = r2; rs1_used_id = u1; rs2_used_id = u2;
        rd_ex = rd; regwrite_ex = rw; memread_ex = mr;
        mc_start_ex = mc; branch_taken_ex = br; dmem_ready = rdy;
        if (!rst_n) exp_cnt = 4'd0;
        e.name = nm;
        e.outs = eo;
        e.cnt  = exp_cnt;
        sb.push_back(e);
        if (eo[6] && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input string nm, input logic [6:0] eo);
        step(nm, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, eo);
    endtask

    task automatic mc_seq(input string nm);
        step({nm, "_start"}, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'b1100010);
        nop({nm, "_busy2"}, 7'b1100011);
        nop({nm, "_busy1"}, 7'b1100011);
        nop({nm, "_idle"}, 7'b0000000);
    endtask

    initial begin
        rst_n = 1'b0;
        exp_cnt = 4'd0;
        rs1_id = '0; rs2_id = '0; rd_ex = '0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0; regwrite_ex = 1'b0; memread_ex = 1'b0;
        mc_start_ex = 1'b0; branch_taken_ex = 1'b0; dmem_ready = 1'b1;
        @(posedge clk);
        #1;

        // reset, with hazard inputs present
        step("reset", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7'b0000000);
        rst_n = 1'b1;
        nop("idle_nop", 7'b0000000);

        // load-use via rs1, two stall cycles, busy in the second only
        step("lu_rs1", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'b1000100);
        nop("lu_hold", 7'b1000101);
        nop("lu_done", 7'b0000000);

        // no-hazard boundaries
        step("ld_x0", 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0000000);
        step("rs2_unused", 5'd0, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0000000);
        step("not_load", 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000);
        step("no_regwr", 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0000000);

        // load-use via rs2; branch during LU_STALL is ignored
        step("lu_rs2", 5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'b1000100);
        step("lu_hold_br", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'b1000101);
        nop("lu2_done", 7'b0000000);

        // branch beats load-use, stays IDLE
        step("lu_and_br", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 7'b0001100);
        nop("after_br", 7'b0000000);

        // multi-cycle op; load-use and branch inputs ignored while MC_BUSY
        step("mc_start", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'b1100010);
        step("mc_busy_lu", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'b1100011);
        step("mc_busy_br", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7'b1100011);
        nop("mc_done", 7'b0000000);

        // branch beats mc_start
        step("br_mc", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7'b0001100);
        nop("after_br_mc", 7'b0000000);

        // freeze for 3 cycles at rem=2, then 2 more MC_BUSY cycles
        step("mc_frz_start", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'b1100010);
        for (int i = 0; i < 3; i++)
            step("mc_frz", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'b1110001);
        nop("mc_rel2", 7'b1100011);
        nop("mc_rel1", 7'b1100011);
        nop("mc_rel_idle", 7'b0000000);

        // freeze in IDLE: branch and mc inputs ignored
        step("frz_idle", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7'b1110000);
        nop("frz_idle_after", 7'b0000000);

        // drive the 4-bit counter past saturation
        for (int i = 0; i < 3; i++) mc_seq("sat");

        // reset mid-MC_BUSY
        step("rst_mc_start", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'b1100010);
        rst_n = 1'b0;
        nop("rst_mid_mc", 7'b0000000);
        rst_n = 1'b1;
        nop("after_rst", 7'b0000000);
        step("post_rst_lu", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'b1000100);
        nop("post_rst_hold", 7'b1000101);
        nop("post_rst_idle", 7'b0000000);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: pending=%0d, expected pending=0", sb.size());
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 Parameter REG_AW, default 5, register address width.
REQ-002 Parameter LU_STALL_CYC, default 1, legal range 1..3, load-use stall cycles.
REQ-003 Parameter MC_LAT, default 4, legal range 2..32, EX-stage cycles of a multi-cycle (mul/div) op.
REQ-004 Parameter CNT_W, default 16, stall performance counter width.
REQ-005 clk  in  1  sole clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-006 rs1_id, rs2_id  in  REG_AW  ID-stage source registers; rs1_used_id, rs2_used_id  in  1  source actually read.
REQ-007 rd_ex  in  REG_AW; regwrite_ex, memread_ex  in  1  EX-stage destination, write enable, load flag.
REQ-008 mc_start_ex  in  1  multi-cycle op entered EX this cycle; branch_taken_ex  in  1  branch/jump resolved taken in EX.
REQ-009 dmem_ready  in  1  data memory ready; low freezes whole pipeline.
REQ-010 stall_if  out  1  hold PC and IF/ID; stall_ex  out  1  hold ID/EX; stall_mem  out  1  hold EX/MEM.
REQ-011 flush_ifid, flush_idex, bubble_exmem  out  1  squash the named pipeline register.
REQ-012 busy  out  1  FSM not IDLE; stall_cnt  out  CNT_W  count of cycles with stall_if high.

Function
REQ-013 FSM states IDLE, LU_STALL, MC_BUSY; remaining-cycle counter rem; FSM exits a non-IDLE state when rem==1, else rem decrements.
REQ-014 Load-use hazard = memread_ex & regwrite_ex & rd_ex!=0 & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)).
REQ-015 IDLE priority, highest first: freeze, branch, multi-cycle start, load-use.
REQ-016 Freeze (dmem_ready==0, any state): stall_if=stall_ex=stall_mem=1, all flush/bubble outputs 0, state and rem held, branch/mc/load-use inputs ignored.
REQ-017 IDLE branch: flush_ifid=flush_idex=1, no stall, stay IDLE; concurrent load-use or mc_start_ex suppressed.
REQ-018 IDLE mc_start_ex: stall_if=stall_ex=bubble_exmem=1 that cycle; if MC_LAT>=3 enter MC_BUSY with rem=MC_LAT-2; total stall = MC_LAT-1 cycles.
REQ-019 MC_BUSY: stall_if=stall_ex=bubble_exmem=1; inputs other than dmem_ready ignored.
REQ-020 IDLE load-use: stall_if=flush_idex=1 that cycle; if LU_STALL_CYC>=2 enter LU_STALL with rem=LU_STALL_CYC-1; total stall = LU_STALL_CYC cycles.
REQ-021 LU_STALL: stall_if=flush_idex=1; load-use re-detection ignored.
REQ-022 branch_taken_ex outside IDLE is ignored; branch_taken_ex with mc_start_ex in IDLE: branch wins.
REQ-023 All stall/flush outputs are combinational from state, rem and inputs; no added latency.
REQ-024 stall_cnt increments on each clock edge where stall_if==1, saturates at all-ones, never wraps.
REQ-025 busy = (state != IDLE).

Reset
REQ-026 rst_n low: state=IDLE, rem=0, stall_cnt=0, every output forced 0 asynchronously.
REQ-027 Reset asserted mid-LU_STALL or mid-MC_BUSY aborts the sequence; first cycle after release evaluates as IDLE.

Structure
REQ-028 Package hazard_pkg holds the FSM state enum and the parameter range constants for LU_STALL_CYC and MC_LAT.
REQ-029 Sub-module hazard_stall_timer (load, value, dec, last flag) implements rem, shared by LU_STALL and MC_BUSY.
REQ-030 Illegal parameter values fail elaboration.

Verification
REQ-031 LU_STALL_CYC=2, load to x5 in EX, rs1_id=5 used -> stall_if and flush_idex high exactly 2 cycles, busy high 1 cycle.
REQ-032 Load to x0, rs1_id=0 used; or rs2_used_id=0 with match -> no stall.
REQ-033 MC_LAT=4, mc_start_ex pulse -> stall_if/stall_ex/bubble_exmem high 3 cycles, then IDLE.
REQ-034 Load-use and branch_taken_ex same cycle -> flush_ifid=flush_idex=1, stall_if=0, state stays IDLE.
REQ-035 dmem_ready low 3 cycles during MC_BUSY rem=2 -> all stalls high, rem held at 2, 2 further MC_BUSY cycles after release.
REQ-036 CNT_W=4, 20 stall cycles -> stall_cnt saturates at 15; rst_n low mid-MC_BUSY -> outputs 0 immediately, busy 0 after release.
